// File: rtl/breath_pwm.sv
// breath_pwm: breathing-LED PWM driver.
// Ramps duty up to a peak, holds, ramps down to zero, holds, repeats.
//
// Ports:
//   sys_clk    system clock
//   sys_rst    synchronous active-high reset
//   en         run enable, low forces IDLE and clears all state
//   step_tick  single-cycle step pulse from the tick generator
//   led        registered PWM LED drive
//   duty       current target duty (cycles high per frame)
//   phase      IDLE=0 RISE=1 PEAK=2 FALL=3 TROUGH=4
//   cycle_done one-cycle pulse when a down-ramp reaches zero

module breath_pwm #(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_MAX   = 1000,
  parameter int DUTY_STEP  = 1,
  parameter int HOLD_TICKS = 0,
  parameter int CNT_W      = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             step_tick,
  output logic             led,
  output logic [CNT_W-1:0] duty,
  output logic [2:0]       phase,
  output logic             cycle_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RISE   = 3'd1,
    PEAK   = 3'd2,
    FALL   = 3'd3,
    TROUGH = 3'd4
  } phase_e;

  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] D_MAX     = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0] D_STEP    = CNT_W'(DUTY_STEP);
  localparam logic [CNT_W-1:0] HOLD_N    = CNT_W'(HOLD_TICKS);
  localparam logic             HOLD_EN   = (HOLD_TICKS != 0);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO      = '0;

  phase_e           state;
  logic [CNT_W-1:0] duty_active;
  logic [CNT_W-1:0] pwm_cnt;
  logic [CNT_W-1:0] hold_cnt;

  logic [CNT_W:0]   sum_up;
  logic [CNT_W-1:0] duty_up;
  logic [CNT_W-1:0] duty_dn;
  logic             hold_last;
  logic             frame_end;

  // One extra bit on the add so a step near the top of the
  // counter range cannot wrap before saturating at the peak.
  assign sum_up    = {1'b0, duty} + {1'b0, D_STEP};
  assign duty_up   = (sum_up >= {1'b0, D_MAX}) ? D_MAX
                                               : sum_up[CNT_W-1:0];
  assign duty_dn   = (duty < D_STEP) ? ZERO : duty - D_STEP;
  assign hold_last = (hold_cnt + ONE) == HOLD_N;
  assign frame_end = (pwm_cnt == FRAME_END);

  assign phase = state;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) begin
      state       <= IDLE;
      duty        <= '0;
      duty_active <= '0;
      pwm_cnt     <= '0;
      hold_cnt    <= '0;
      led         <= 1'b0;
      cycle_done  <= 1'b0;
    end else if (state == IDLE) begin
      // Ticks are ignored on the enabling cycle.
      state      <= RISE;
      pwm_cnt    <= '0;
      led        <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      led        <= (pwm_cnt < duty_active);

      // Shadow duty only moves at the frame wrap, so a frame
      // always carries one whole duty value.
      if (frame_end) begin
        pwm_cnt     <= '0;
        duty_active <= duty;
      end else begin
        pwm_cnt <= pwm_cnt + ONE;
      end

      if (step_tick) begin
        unique case (state)
          RISE: begin
            duty <= duty_up;
            if (duty_up == D_MAX)
              state <= HOLD_EN ? PEAK : FALL;
          end
          PEAK: begin
            if (hold_last) begin
              hold_cnt <= '0;
              state    <= FALL;
            end else begin
              hold_cnt <= hold_cnt + ONE;
            end
          end
          FALL: begin
            duty <= duty_dn;
            if (duty_dn == ZERO) begin
              state      <= HOLD_EN ? TROUGH : RISE;
              cycle_done <= 1'b1;
            end
          end
          TROUGH: begin
            if (hold_last) begin
              hold_cnt <= '0;
              state    <= RISE;
            end else begin
              hold_cnt <= hold_cnt + ONE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_breath_pwm.sv
// tb_breath_pwm: three breath_pwm configurations driven by shared
// stimulus, checked every cycle against a breath-position model.

module tb_breath_pwm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic en   = 1'b1;
  logic tick = 1'b0;

  logic [2:0]       led_w;
  logic [2:0]       done_w;
  logic [2:0][15:0] duty_w;
  logic [2:0][2:0]  phase_w;

  breath_pwm #(
    .PWM_PERIOD(10), .DUTY_MAX(10), .DUTY_STEP(3),
    .HOLD_TICKS(2), .CNT_W(16)
  ) u0 (
    .sys_clk(clk), .sys_rst(rst), .en(en), .step_tick(tick),
    .led(led_w[0]), .duty(duty_w[0]), .phase(phase_w[0]),
    .cycle_done(done_w[0])
  );

  breath_pwm #(
    .PWM_PERIOD(10), .DUTY_MAX(10), .DUTY_STEP(3),
    .HOLD_TICKS(0), .CNT_W(16)
  ) u1 (
    .sys_clk(clk), .sys_rst(rst), .en(en), .step_tick(tick),
    .led(led_w[1]), .duty(duty_w[1]), .phase(phase_w[1]),
    .cycle_done(done_w[1])
  );

  breath_pwm #(
    .PWM_PERIOD(10), .DUTY_MAX(10), .DUTY_STEP(10),
    .HOLD_TICKS(2), .CNT_W(16)
  ) u2 (
    .sys_clk(clk), .sys_rst(rst), .en(en), .step_tick(tick),
    .led(led_w[2]), .duty(duty_w[2]), .phase(phase_w[2]),
    .cycle_done(done_w[2])
  );

  int pp[3] = '{10, 10, 10};
  int pm[3] = '{10, 10, 10};
  int ps[3] = '{3, 3, 10};
  int ph[3] = '{2, 0, 2};

  int exp_d0[12] = '{3, 6, 9, 10, 10, 10, 7, 4, 1, 0, 0, 0};
  int exp_p0[12] = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4, 1};
  int exp_d1[12] = '{3, 6, 9, 10, 7, 4, 1, 0, 3, 6, 9, 10};
  int exp_p1[12] = '{1, 1, 1, 3, 3, 3, 3, 1, 1, 1, 1, 3};
  int exp_d2[12] = '{10, 10, 10, 0, 0, 0, 10, 10, 10, 0, 0, 0};
  int exp_p2[12] = '{2, 2, 3, 4, 4, 1, 2, 2, 3, 4, 4, 1};

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Model state: breath position = ticks consumed since the last
  // start of a rise, plus a plain frame counter for the LED.
  bit m_on[3];
  int m_pos[3];
  int m_cnt[3];
  int m_act[3];
  bit m_led[3];
  bit m_done[3];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int n_of(input int c);
    return (pm[c] + ps[c] - 1) / ps[c];
  endfunction

  function automatic int len_of(input int c);
    return 2 * n_of(c) + 2 * ph[c];
  endfunction

  function automatic int duty_of(input int c, input int p);
    int n;
    int d;
    n = n_of(c);
    if (p <= n) begin
      d = p * ps[c];
      return (d > pm[c]) ? pm[c] : d;
    end
    if (p < n + ph[c]) return pm[c];
    d = pm[c] - (p - n - ph[c]) * ps[c];
    return (d < 0) ? 0 : d;
  endfunction

  function automatic int phase_of(input int c, input int p);
    int n;
    n = n_of(c);
    if (p < n) return 1;
    if (p < n + ph[c]) return 2;
    if (p < 2 * n + ph[c]) return 3;
    return 4;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (rst || !en) begin
        m_on[c] = 0; m_pos[c] = 0; m_cnt[c] = 0;
        m_act[c] = 0; m_led[c] = 0; m_done[c] = 0;
      end else if (!m_on[c]) begin
        m_on[c] = 1; m_pos[c] = 0; m_cnt[c] = 0;
        m_act[c] = 0; m_led[c] = 0; m_done[c] = 0;
      end else begin
        int np;
        m_led[c] = (m_cnt[c] < m_act[c]);
        if (m_cnt[c] == pp[c] - 1) begin
          m_act[c] = duty_of(c, m_pos[c]);
          m_cnt[c] = 0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
        m_done[c] = 0;
        if (tick) begin
          np = m_pos[c] + 1;
          m_done[c] = (np == 2 * n_of(c) + ph[c]);
          if (np == len_of(c)) np = 0;
          m_pos[c] = np;
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("led%0d", c), int'(led_w[c]), int'(m_led[c]));
        chk($sformatf("duty%0d", c), int'(duty_w[c]),
            m_on[c] ? duty_of(c, m_pos[c]) : 0);
        chk($sformatf("phase%0d", c), int'(phase_w[c]),
            m_on[c] ? phase_of(c, m_pos[c]) : 0);
        chk($sformatf("done%0d", c), int'(done_w[c]),
            int'(m_done[c]));
      end
    end
  end

  task automatic pulse(input int gap);
    repeat (gap) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    int r;
    int hi;
    int dn;

    // Reset held three edges with en high and ticks toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        chk("rst_led", int'(led_w[c]), 0);
        chk("rst_duty", int'(duty_w[c]), 0);
        chk("rst_phase", int'(phase_w[c]), 0);
        chk("rst_done", int'(done_w[c]), 0);
      end
      tick = ~tick;
      if (i == 2) rst = 1'b0;
    end
    @(negedge clk);
    tick = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rel_phase", int'(phase_w[c]), 1);
      chk("rel_duty", int'(duty_w[c]), 0);
    end

    // One full breath of spaced ticks.
    for (int k = 0; k < 12; k++) begin
      pulse($urandom_range(2, 12));
      chk("br_d0", int'(duty_w[0]), exp_d0[k]);
      chk("br_p0", int'(phase_w[0]), exp_p0[k]);
      chk("br_c0", int'(done_w[0]), (k == 9) ? 1 : 0);
      chk("br_d1", int'(duty_w[1]), exp_d1[k]);
      chk("br_p1", int'(phase_w[1]), exp_p1[k]);
      chk("br_c1", int'(done_w[1]), (k == 7) ? 1 : 0);
      chk("br_d2", int'(duty_w[2]), exp_d2[k]);
      chk("br_p2", int'(phase_w[2]), exp_p2[k]);
      chk("br_c2", int'(done_w[2]), (k == 3 || k == 9) ? 1 : 0);
    end

    // Walk u0 into FALL at duty 7, then drop enable.
    for (int k = 0; k < 7; k++) pulse(3);
    chk("pre_drop_duty", int'(duty_w[0]), 7);
    chk("pre_drop_phase", int'(phase_w[0]), 3);
    en = 1'b0;
    @(negedge clk);
    chk("drop_phase", int'(phase_w[0]), 0);
    chk("drop_duty", int'(duty_w[0]), 0);
    chk("drop_led", int'(led_w[0]), 0);
    en = 1'b1;
    @(negedge clk);
    chk("reen_phase", int'(phase_w[0]), 1);
    pulse(2);
    chk("reen_duty", int'(duty_w[0]), 3);

    // Duty 3 of a 10-cycle frame: 9 high cycles in any 30.
    repeat (25) @(negedge clk);
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      hi += int'(led_w[0]);
    end
    chk("frame_hi", hi, 9);

    // Randomized run; every cycle is held against the model.
    dn = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 999);
      rst = (r < 2);
      if (r >= 2 && r < 8) en = ~en;
      else if (!en && r >= 950) en = 1'b1;
      tick = ($urandom_range(0, (i < 1500) ? 3 : 11) == 0);
      dn += int'(done_w[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    tick = 1'b0;
    if (dn == 0) chk("rand_any_done", dn, 1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
